// File: rtl/xrv_div_ctrl.sv
// xrv_div_ctrl: sequencer between the execute stage and the shared iterative
// 32-bit divider used for DIV / DIVU / REM / REMU.
//
// Accepts one request at a time. Divide-by-zero and signed overflow are
// answered locally, without starting the divider. All other requests are
// sent to the divider as unsigned magnitudes, and the result sign is fixed
// up on return. A watchdog turns a lost divider result into an error
// response. A flush kills the in-flight request. If the divider was already
// started, its eventual result is drained and discarded.
//
// Ports:
//   clk, rstb           clock, asynchronous active-low reset
//   req_*               request handshake (op, rs1, rs2, tag); req_ready only in IDLE
//   flush               kill in-flight request (highest priority)
//   rsp_*               tagged result handshake; rsp_err marks a timeout result
//   div_valid           one-cycle start pulse to the divider
//   div_dividend/divisor unsigned operand magnitudes
//   div_is_sign         always 0 (divider only sees magnitudes)
//   div_optype          0 quotient, 1 remainder
//   div_result(_valid)  divider result and strobe
module xrv_div_ctrl #(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 48
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             div_valid,
    output logic [31:0]      div_dividend,
    output logic [31:0]      div_divisor,
    output logic             div_is_sign,
    output logic             div_optype,
    input  logic [31:0]      div_result,
    input  logic             div_result_valid
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    // Two's-complement absolute value; abs(0x80000000) stays 0x80000000.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        if (x[31]) begin
            abs32 = ~x + 32'd1;
        end else begin
            abs32 = x;
        end
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [WD_W-1:0] wd_cnt_r;
    logic            op_rem_r;
    logic            neg_q_r;
    logic            neg_r_r;

    logic            accept_s;
    logic            req_signed_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic [31:0]     special_data_s;
    logic            sel_neg_s;
    logic            wd_expire_s;
    logic            issue_s;
    logic            rsp_set_s;
    logic            rsp_clr_s;
    logic [31:0]     rsp_data_nxt_s;
    logic            rsp_err_nxt_s;

    assign req_ready    = (state_r == ST_IDLE);
    assign div_is_sign  = 1'b0;
    // A flush in IDLE blocks acceptance even though req_ready is high.
    assign accept_s     = req_ready & req_valid & ~flush;
    assign req_signed_s = ~req_op[0];
    assign div_zero_s   = (req_rs2 == 32'd0);
    assign ovf_s        = req_signed_s & (req_rs1 == 32'h8000_0000) & (req_rs2 == 32'hFFFF_FFFF);
    assign sel_neg_s    = op_rem_r ? neg_r_r : neg_q_r;
    assign wd_expire_s  = (wd_cnt_r == WD_LAST);

    // Locally resolved results: divide-by-zero first, then signed overflow.
    always_comb begin
        special_data_s = 32'd0;
        if (div_zero_s) begin
            special_data_s = req_op[1] ? req_rs1 : 32'hFFFF_FFFF;
        end else begin
            special_data_s = req_op[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // Next-state and per-cycle control decode; flush outranks every other event.
    always_comb begin
        state_nxt_s    = state_r;
        issue_s        = 1'b0;
        rsp_set_s      = 1'b0;
        rsp_clr_s      = 1'b0;
        rsp_data_nxt_s = 32'd0;
        rsp_err_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (div_zero_s || ovf_s) begin
                        state_nxt_s    = ST_RESP;
                        rsp_set_s      = 1'b1;
                        rsp_data_nxt_s = special_data_s;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                        issue_s     = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (flush) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_nxt_s = ST_DRAIN;
                end else if (div_result_valid) begin
                    state_nxt_s    = ST_RESP;
                    rsp_set_s      = 1'b1;
                    rsp_data_nxt_s = sel_neg_s ? (~div_result + 32'd1) : div_result;
                end else if (wd_expire_s) begin
                    state_nxt_s    = ST_RESP;
                    rsp_set_s      = 1'b1;
                    rsp_err_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (flush || rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                    rsp_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (div_result_valid || wd_expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Watchdog: cleared while issuing, counts every WAIT/DRAIN cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wd_cnt_r <= '0;
        end else if (state_r == ST_ISSUE) begin
            wd_cnt_r <= '0;
        end else if (((state_r == ST_WAIT) || (state_r == ST_DRAIN)) && !wd_expire_s) begin
            wd_cnt_r <= wd_cnt_r + WD_ONE;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Request capture: tag and sign-correction flags.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rsp_tag  <= '0;
            op_rem_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
        end else if (accept_s) begin
            rsp_tag  <= req_tag;
            op_rem_r <= req_op[1];
            neg_q_r  <= req_signed_s & (req_rs1[31] ^ req_rs2[31]);
            neg_r_r  <= req_signed_s & req_rs1[31];
        end else begin
            rsp_tag  <= rsp_tag;
            op_rem_r <= op_rem_r;
            neg_q_r  <= neg_q_r;
            neg_r_r  <= neg_r_r;
        end
    end

    // Divider command: the pulse is high exactly for the ISSUE cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            div_valid    <= 1'b0;
            div_dividend <= 32'd0;
            div_divisor  <= 32'd0;
            div_optype   <= 1'b0;
        end else if (issue_s) begin
            div_valid    <= 1'b1;
            div_dividend <= req_signed_s ? abs32(req_rs1) : req_rs1;
            div_divisor  <= req_signed_s ? abs32(req_rs2) : req_rs2;
            div_optype   <= req_op[1];
        end else begin
            div_valid    <= 1'b0;
        end
    end

    // Response register: data/err load on entry to RESP and hold until consumed.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (rsp_set_s) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rsp_data_nxt_s;
            rsp_err   <= rsp_err_nxt_s;
        end else if (rsp_clr_s) begin
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= rsp_valid;
        end
    end

endmodule

// File: tb/tb_xrv_div_ctrl.sv
// Scoreboard bench for xrv_div_ctrl: stimulus pushes hand-computed divider
// commands and responses; a negedge monitor pops and compares them.
module tb_xrv_div_ctrl;

    localparam int TAG_W    = 5;
    localparam int TIMEOUT  = 48;
    localparam int STUB_LAT = 33;

    typedef struct packed {
        logic [31:0] dividend;
        logic [31:0] divisor;
        logic        optype;
    } div_t;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rstb;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             div_valid;
    logic [31:0]      div_dividend;
    logic [31:0]      div_divisor;
    logic             div_is_sign;
    logic             div_optype;
    logic [31:0]      div_result;
    logic             div_result_valid;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   rsp_cnt = 0;
    div_t exp_div_q[$];
    rsp_t exp_rsp_q[$];
    div_t d_pop;
    rsp_t r_pop;

    logic        stub_mute = 1'b0;
    logic        stub_busy = 1'b0;
    int          stub_cnt  = 0;
    logic [31:0] stub_res  = 32'd0;

    xrv_div_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .div_valid(div_valid), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_is_sign(div_is_sign), .div_optype(div_optype),
        .div_result(div_result), .div_result_valid(div_result_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stub divider: answers STUB_LAT cycles after the start pulse unless muted.
    always @(negedge clk) begin
        div_result_valid = 1'b0;
        if (stub_busy) begin
            if (stub_cnt == 1) begin
                div_result_valid = 1'b1;
                div_result       = stub_res;
                stub_busy        = 1'b0;
            end else begin
                stub_cnt--;
            end
        end
        if (rstb && div_valid && !stub_mute) begin
            stub_busy = 1'b1;
            stub_cnt  = STUB_LAT;
            if (div_divisor == 32'd0) begin
                stub_res = div_optype ? div_dividend : 32'hFFFF_FFFF;
            end else begin
                stub_res = div_optype ? (div_dividend % div_divisor) : (div_dividend / div_divisor);
            end
        end
    end

    // Monitor: compares divider commands and consumed responses against the queues.
    always @(negedge clk) begin
        if (rstb) begin
            if (div_valid) begin
                if (exp_div_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL div_unexpected: got pulse with dividend %h, expected no pulse", div_dividend);
                end else begin
                    d_pop = exp_div_q.pop_front();
                    chk("div_dividend", div_dividend, d_pop.dividend);
                    chk("div_divisor", div_divisor, d_pop.divisor);
                    chk("div_optype", 32'(div_optype), 32'(d_pop.optype));
                    chk("div_is_sign", 32'(div_is_sign), 32'd0);
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                if (exp_rsp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got data %h tag %0d, expected no response", rsp_data, rsp_tag);
                end else begin
                    r_pop = exp_rsp_q.pop_front();
                    chk("rsp_data", rsp_data, r_pop.data);
                    chk("rsp_tag", 32'(rsp_tag), 32'(r_pop.tag));
                    chk("rsp_err", 32'(rsp_err), 32'(r_pop.err));
                end
            end
        end
    end

    // Queue expectations, offer the request, return just after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [TAG_W-1:0] tag,
                        input logic has_div, input logic [31:0] e_dvd, input logic [31:0] e_dvs,
                        input logic has_rsp, input logic [31:0] e_data, input logic e_err);
        int n = 0;
        div_t dv;
        rsp_t rv;
        dv = '{dividend: e_dvd, divisor: e_dvs, optype: op[1]};
        rv = '{data: e_data, tag: tag, err: e_err};
        if (has_div) exp_div_q.push_back(dv);
        if (has_rsp) exp_rsp_q.push_back(rv);
        req_op    = op;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_tag   = tag;
        req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        chk("send_accept_timeout", 32'(n < 200), 32'd1);
        @(posedge clk); #2;
        req_valid = 1'b0;
    endtask

    // Bounded wait for the controller to return to IDLE with nothing pending.
    task automatic wait_idle();
        int n = 0;
        while (!(req_ready && exp_rsp_q.size() == 0 && exp_div_q.size() == 0) && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        chk("wait_idle_timeout", 32'(n < 300), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt0;
        rstb      = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_rs1   = 32'd0;
        req_rs2   = 32'd0;
        req_tag   = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        #12;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_div_valid", 32'(div_valid), 32'd0);
        chk("reset_div_dividend", div_dividend, 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #2;
        rstb = 1'b1;
        @(posedge clk); #2;

        // Basic signed division through the divider.
        send(2'd0, 32'd7, 32'd2, 5'd3, 1'b1, 32'd7, 32'd2, 1'b1, 32'd3, 1'b0);
        chk("issue_pulse_after_accept", 32'(div_valid), 32'd1);
        wait_idle();
        // Negative dividend: magnitude to divider, sign fix on return.
        send(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1, 32'd7, 32'd2, 1'b1, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        send(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1, 32'd7, 32'd2, 1'b1, 32'hFFFF_FFFD, 1'b0);
        wait_idle();
        // Unsigned op with top bit set must not be sign-converted.
        send(2'd1, 32'hFFFF_FFF9, 32'd2, 5'd14, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 1'b0);
        wait_idle();

        // Divide by zero resolved locally, response one cycle after acceptance.
        send(2'd1, 32'd5, 32'd0, 5'd6, 1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("divz_rsp_latency", 32'(rsp_valid), 32'd1);
        chk("divz_no_pulse", 32'(div_valid), 32'd0);
        wait_idle();
        send(2'd3, 32'd5, 32'd0, 5'd7, 1'b0, 32'd0, 32'd0, 1'b1, 32'd5, 1'b0);
        chk("remz_rsp_latency", 32'(rsp_valid), 32'd1);
        wait_idle();

        // Signed overflow resolved locally.
        send(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b0, 32'd0, 32'd0, 1'b1, 32'h8000_0000, 1'b0);
        chk("ovf_rsp_latency", 32'(rsp_valid), 32'd1);
        wait_idle();
        send(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0);
        wait_idle();

        // Back-pressure: response held stable for 10 cycles.
        rsp_ready = 1'b0;
        send(2'd1, 32'd100, 32'd7, 5'd10, 1'b1, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("hold_rsp_arrives", 32'(n < 100), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_data", rsp_data, 32'd14);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #2;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("release_req_ready", 32'(req_ready), 32'd1);
        send(2'd3, 32'd100, 32'd7, 5'd11, 1'b1, 32'd100, 32'd7, 1'b1, 32'd2, 1'b0);
        wait_idle();

        // Flush five cycles after the pulse: strobe swallowed in DRAIN, no response.
        cnt0 = rsp_cnt;
        send(2'd0, 32'd9, 32'd3, 5'd12, 1'b1, 32'd9, 32'd3, 1'b0, 32'd0, 1'b0);
        repeat (5) begin
            @(posedge clk); #2;
        end
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        chk("flush_req_ready_low", 32'(req_ready), 32'd0);
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain_returns_idle", 32'(n < 100), 32'd1);
        chk("drain_waited_for_strobe", 32'(stub_busy), 32'd0);
        repeat (3) begin
            @(posedge clk); #2;
        end
        chk("flush_no_response", 32'(rsp_cnt - cnt0), 32'd0);

        // Lost divider result: error response after TIMEOUT WAIT cycles.
        stub_mute = 1'b1;
        send(2'd1, 32'd10, 32'd3, 5'd13, 1'b1, 32'd10, 32'd3, 1'b1, 32'd0, 1'b1);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("timeout_latency", 32'(n), 32'(TIMEOUT + 1));
        wait_idle();
        stub_mute = 1'b0;

        // Flush in IDLE blocks acceptance.
        req_op    = 2'd1;
        req_rs1   = 32'd8;
        req_rs2   = 32'd0;
        req_tag   = 5'd15;
        req_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk); #2;
        chk("idle_flush_still_idle", 32'(req_ready), 32'd1);
        chk("idle_flush_no_rsp", 32'(rsp_valid), 32'd0);
        chk("idle_flush_no_pulse", 32'(div_valid), 32'd0);
        req_valid = 1'b0;
        flush     = 1'b0;

        repeat (5) begin
            @(posedge clk); #2;
        end
        chk("leftover_div_expect", 32'(exp_div_q.size()), 32'd0);
        chk("leftover_rsp_expect", 32'(exp_rsp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xrv_div_ctrl.md
Name: xrv_div_ctrl

Overview:
Sequencer between the execute stage and the shared iterative 32-bit divider (DIV/DIVU/REM/REMU).
- Accepts one request at a time over a valid/ready handshake.
- Resolves RISC-V special cases (divide-by-zero, signed overflow) locally, without starting the divider.
- Sends unsigned magnitudes to the divider and applies sign correction on the result.
- Returns a tagged result over a valid/ready handshake, and supports pipeline flush.

Parameters:
TAG_W, 5, width of destination-register tag carried with each request
TIMEOUT, 48, max cycles in WAIT before a divider result is declared lost

Ports:
clk  input  1  clock
rstb  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept (state IDLE)
req_op  input  2  0 DIV, 1 DIVU, 2 REM, 3 REMU
req_rs1  input  32  dividend
req_rs2  input  32  divisor
req_tag  input  TAG_W  destination tag
flush  input  1  kill in-flight request
rsp_valid  output  1  result present
rsp_ready  input  1  consumer accepts result
rsp_data  output  32  final result
rsp_tag  output  TAG_W  tag of result
rsp_err  output  1  result produced by timeout (rsp_data=0)
div_valid  output  1  one-cycle start pulse to divider
div_dividend  output  32  unsigned dividend magnitude
div_divisor  output  32  unsigned divisor magnitude
div_is_sign  output  1  tied 0 (magnitudes only)
div_optype  output  1  0 quotient, 1 remainder
div_result  input  32  divider output
div_result_valid  input  1  divider result strobe

Behaviour:
- Clocking and reset: single clock domain; all flops reset asynchronously on rstb low.
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, div_valid=0, div_dividend=0, div_divisor=0, div_optype=0.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN. req_ready=1 only in IDLE.
- IDLE, accept on req_valid & req_ready:
  - Latch op, tag, neg_q = signed & (rs1[31]^rs2[31]), neg_r = signed & rs1[31].
  - Magnitudes: signed ops use two's-complement abs; abs(0x80000000)=0x80000000.
  - rs2==0: rsp_data = quotient ops 0xFFFFFFFF, remainder ops rs1; go RESP. rsp_valid rises the cycle after acceptance.
  - Signed op with rs1==0x80000000 and rs2==0xFFFFFFFF: DIV gives 0x80000000, REM gives 0; go RESP.
  - Otherwise go ISSUE.
- ISSUE: div_valid=1 for exactly one cycle, with div_dividend/div_divisor/div_optype registered. Clear the watchdog counter; go WAIT.
- WAIT: on div_result_valid, rsp_data = div_result negated if the selected sign flag is set (neg_q for quotient, neg_r for remainder), rsp_err=0; go RESP. div_result_valid outside WAIT/DRAIN is ignored.
- Watchdog: counter increments each WAIT cycle. On reaching TIMEOUT without a result: rsp_data=0, rsp_err=1; go RESP.
- RESP: rsp_valid held with stable data/tag/err until rsp_ready; then rsp_valid=0 and go IDLE next cycle. Back-to-back requests therefore have at least one IDLE cycle between them.
- Flush, priority over all other transitions in the same cycle:
  - In ISSUE: go DRAIN (the pulse already launched counts as issued).
  - In WAIT: go DRAIN.
  - In RESP: drop rsp_valid, go IDLE.
  - In IDLE: any request offered that cycle is not accepted.
  - A simultaneous div_result_valid in WAIT is discarded.
- DRAIN: wait for div_result_valid or the watchdog expiry, discard the result, go IDLE. No response is produced.
- Reset mid-operation: everything returns to reset values immediately. The divider is not notified; any stale result strobe arrives in IDLE and is ignored.

Test Plan:
- DIV rs1=7, rs2=2 with a stub divider (33-cycle latency) -> one div_valid pulse, divisor 2, rsp_data=3, tag echoed, rsp_err=0.
- REM rs1=0xFFFFFFF9 (-7), rs2=2 -> div_dividend=7, rsp_data=0xFFFFFFFF (-1); DIV of the same operands -> 0xFFFFFFFD (-3).
- DIVU rs1=5, rs2=0 -> no div_valid, rsp_valid at acceptance+1, rsp_data=0xFFFFFFFF; REMU -> rsp_data=5.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> no div_valid, rsp_data=0x80000000; REM -> rsp_data=0.
- Hold rsp_ready=0 for 10 cycles -> rsp_valid/rsp_data stable, req_ready=0; release -> IDLE next cycle, next request accepted.
- Flush 5 cycles after div_valid -> no rsp_valid; the divider strobe is swallowed in DRAIN, then IDLE. Stub that never responds -> rsp_err=1 and rsp_data=0 after TIMEOUT=48 WAIT cycles.
